// File: rtl/dense_seq_ctrl.sv
// ----------------------------------------------------------------------------
// dense_seq_ctrl
//   Sequencer for the integer dense-layer front datapath. Accepts H feature
//   rows per image from upstream over a valid/ready handshake and issues each
//   one to the datapath as a one-cycle strobe. Strobes are spaced
//   ROW_CYCLES+1 cycles apart when upstream keeps up. It then gathers B serial
//   datapath outputs into a result vector and presents that vector
//   downstream. After the downstream handshake it pulses an accumulator clear.
//
//   Optional feature macro: DENSE_SEQ_ARGMAX_EN
//     When defined, adds argmax_o: the index of the largest signed result.
//     Ties keep the lowest index. It is valid together with out_valid.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      upstream row handshake (W*D*DATA_WIDTH bits)
//   dp_valid_o/dp_data_o           row strobe and held row to the datapath
//   dp_valid_i/dp_data_i           serial datapath outputs
//   dp_clear_o                     one-cycle accumulator clear after handshake
//   out_valid/out_ready/out_data   result vector handshake, slot k at [k*DW +: DW]
//   busy                           sequencer not idle
//   ovf                            sticky: datapath strobe seen outside COLLECT
//   argmax_o (DENSE_SEQ_ARGMAX_EN) index of the maximum result
// ----------------------------------------------------------------------------
module dense_seq_ctrl #(
    parameter int H          = 3,
    parameter int W          = 3,
    parameter int D          = 12,
    parameter int B          = 64,
    parameter int DATA_WIDTH = 8,
    parameter int ROW_CYCLES = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W*D*DATA_WIDTH-1:0]    in_data,
    output logic                         dp_valid_o,
    output logic [W*D*DATA_WIDTH-1:0]    dp_data_o,
    input  logic                         dp_valid_i,
    input  logic [DATA_WIDTH-1:0]        dp_data_i,
    output logic                         dp_clear_o,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [B*DATA_WIDTH-1:0]      out_data,
    output logic                         busy,
    output logic                         ovf
`ifdef DENSE_SEQ_ARGMAX_EN
    ,
    output logic [((B > 1) ? $clog2(B) : 1)-1:0] argmax_o
`endif
);

    localparam int ROW_W = W * D * DATA_WIDTH;
    localparam int RCW   = (H > 1) ? $clog2(H) : 1;
    localparam int OCW   = (B > 1) ? $clog2(B) : 1;
    localparam int WCW   = $clog2(ROW_CYCLES);

    localparam logic [RCW-1:0] ROW_LAST  = RCW'(H - 1);
    localparam logic [OCW-1:0] OUT_LAST  = OCW'(B - 1);
    localparam logic [OCW-1:0] OUT_FIRST = OCW'(0);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(ROW_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
    localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_FETCH   = 3'd3,
        S_COLLECT = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic [RCW-1:0]          row_cnt_r;
    logic [OCW-1:0]          out_cnt_r;
    logic [WCW-1:0]          wait_cnt_r;
    logic [ROW_W-1:0]        dp_data_r;
    logic [B*DATA_WIDTH-1:0] out_data_r;
    logic                    ovf_r;

    logic                    in_ready_r;
    logic                    dp_valid_r;
    logic                    dp_clear_r;
    logic                    out_valid_r;
    logic                    busy_r;

    logic                    in_ready_s;
    logic                    dp_valid_s;
    logic                    dp_clear_s;
    logic                    out_valid_s;
    logic                    busy_s;

    logic                    accept_s;
    logic                    wait_done_s;

    // Upstream handshake uses the registered ready that the source also sees.
    assign accept_s = in_valid & in_ready_r;
    // The countdown runs from ROW_CYCLES-1 and leaves WAIT on the edge where it reaches 0.
    // This gives a row period of ROW_CYCLES+1 cycles: ISSUE, ROW_CYCLES-1 WAIT cycles and one FETCH.
    assign wait_done_s = (wait_cnt_r <= WAIT_ONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) next_state_s = S_ISSUE;
                else          next_state_s = S_IDLE;
            end
            S_ISSUE: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done_s) begin
                    if (row_cnt_r == ROW_LAST) next_state_s = S_COLLECT;
                    else                       next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_FETCH: begin
                if (accept_s) next_state_s = S_ISSUE;
                else          next_state_s = S_FETCH;
            end
            S_COLLECT: begin
                if (dp_valid_i && (out_cnt_r == OUT_LAST)) next_state_s = S_OUT;
                else                                       next_state_s = S_COLLECT;
            end
            S_OUT: begin
                // out_valid is high throughout OUT, so out_ready alone completes the handshake.
                if (out_ready) next_state_s = S_IDLE;
                else           next_state_s = S_OUT;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so that the registered outputs line up with the state they describe.
    always_comb begin
        in_ready_s  = 1'b0;
        dp_valid_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (next_state_s)
            S_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            S_ISSUE:   dp_valid_s  = 1'b1;
            S_WAIT:    busy_s      = 1'b1;
            S_FETCH:   in_ready_s  = 1'b1;
            S_COLLECT: busy_s      = 1'b1;
            S_OUT:     out_valid_s = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
        if ((state_r == S_OUT) && out_ready) dp_clear_s = 1'b1;
        else                                 dp_clear_s = 1'b0;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            dp_valid_r  <= 1'b0;
            dp_clear_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            dp_valid_r  <= dp_valid_s;
            dp_clear_r  <= dp_clear_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Row latch, pacing counters and result slot capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_r  <= {RCW{1'b0}};
            out_cnt_r  <= {OCW{1'b0}};
            wait_cnt_r <= {WCW{1'b0}};
            dp_data_r  <= {ROW_W{1'b0}};
            out_data_r <= {(B*DATA_WIDTH){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        dp_data_r <= in_data;
                        row_cnt_r <= {RCW{1'b0}};
                    end
                end
                S_FETCH: begin
                    if (accept_s) dp_data_r <= in_data;
                end
                S_ISSUE: begin
                    wait_cnt_r <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_done_s) begin
                        wait_cnt_r <= WAIT_ZERO;
                        if (row_cnt_r == ROW_LAST) out_cnt_r <= OUT_FIRST;
                        else                       row_cnt_r <= row_cnt_r + RCW'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                S_COLLECT: begin
                    if (dp_valid_i) begin
                        out_data_r[out_cnt_r*DATA_WIDTH +: DATA_WIDTH] <= dp_data_i;
                        // Saturate on the last slot so a stray extra strobe can never wrap into slot 0.
                        if (out_cnt_r != OUT_LAST) out_cnt_r <= out_cnt_r + OCW'(1);
                    end
                end
                default: begin
                    out_cnt_r <= out_cnt_r;
                end
            endcase
        end
    end

    // Sticky flag for datapath strobes that arrive outside COLLECT; those values are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (dp_valid_i && (state_r != S_COLLECT)) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

`ifdef DENSE_SEQ_ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_r;
    logic [OCW-1:0]        idx_r;
    logic                  better_s;

    // Slot 0 always seeds the running max; only a strictly greater value moves the index, so ties keep the lowest index.
    assign better_s = (out_cnt_r == OUT_FIRST) || ($signed(dp_data_i) > $signed(max_r));

    // Running signed maximum over the collected outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_r <= {DATA_WIDTH{1'b0}};
            idx_r <= {OCW{1'b0}};
        end else if ((state_r == S_COLLECT) && dp_valid_i && better_s) begin
            max_r <= dp_data_i;
            idx_r <= out_cnt_r;
        end else begin
            max_r <= max_r;
            idx_r <= idx_r;
        end
    end

    assign argmax_o = idx_r;
`endif

    assign in_ready   = in_ready_r;
    assign dp_valid_o = dp_valid_r;
    assign dp_data_o  = dp_data_r;
    assign dp_clear_o = dp_clear_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign ovf        = ovf_r;

endmodule
